// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage RV32 core.
// Tracks in-flight loads over a configurable load-to-use window, freezes the
// front end while a multi-cycle EX op (MUL/DIV) runs, squashes on taken
// branches, and counts stall cycles in a saturating counter. All control
// outputs are combinational from the current state and inputs.
module hazard_ctrl #(
    parameter int REG_AW    = 5,
    parameter int LOAD_LAT  = 1,
    parameter int MULTI_LAT = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_multi_start,
    input  logic              branch_taken,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              ex_hold,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int MC_W = $clog2(MULTI_LAT);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mc_state_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
    } sb_entry_t;

    // True when a scoreboard entry produces a register the ID instruction reads.
    // Entries with rd=0 are never valid, so x0 can never cause a hazard.
    function automatic logic f_hit(input sb_entry_t e,
                                   input logic [REG_AW-1:0] rs1,
                                   input logic [REG_AW-1:0] rs2,
                                   input logic u1,
                                   input logic u2);
        return e.valid && ((u1 && (rs1 == e.rd)) || (u2 && (rs2 == e.rd)));
    endfunction

    mc_state_t        r_state;
    mc_state_t        w_state_nxt;
    logic [MC_W-1:0]  r_mc;
    logic [MC_W-1:0]  w_mc_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    sb_entry_t        w_entry0;
    logic             w_hold;
    logic             w_sb_hit;
    logic             w_lh;

    // Entry 0 is the load currently in EX; it needs no storage.
    assign w_entry0.valid = ex_mem_read && (ex_rd != '0);
    assign w_entry0.rd    = ex_rd;

    // The final BUSY cycle (mc==1) is the cycle the op leaves EX, so the hold
    // covers the start cycle plus MULTI_LAT-2 BUSY cycles: MULTI_LAT-1 in all.
    assign w_hold = ((r_state == IDLE) && ex_multi_start) ||
                    ((r_state == BUSY) && (r_mc != MC_W'(1)));

    generate
        if (LOAD_LAT > 1) begin : g_sb
            sb_entry_t r_sb [1:LOAD_LAT-1];

            // Age older loads by one slot per advancing cycle; frozen while EX is held.
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples the pre-edge value of its neighbour, which is what makes a
            // shift register shift by exactly one slot.
            always_ff @(posedge clk) begin
                if (rst) begin
                    // NOTE: this small array is reset on purpose: a stale valid
                    // entry after reset would raise a false load hazard.
                    for (int k = 1; k < LOAD_LAT; k++) begin
                        r_sb[k] <= '0;
                    end
                end else if (!w_hold) begin
                    r_sb[1] <= w_entry0;
                    for (int k = 2; k < LOAD_LAT; k++) begin
                        r_sb[k] <= r_sb[k-1];
                    end
                end
            end

            // Any older in-flight load that the ID instruction depends on.
            always_comb begin
                w_sb_hit = 1'b0;
                for (int k = 1; k < LOAD_LAT; k++) begin
                    w_sb_hit = w_sb_hit |
                               f_hit(r_sb[k], id_rs1, id_rs2, id_rs1_used, id_rs2_used);
                end
            end
        end else begin : g_no_sb
            assign w_sb_hit = 1'b0;
        end
    endgenerate

    assign w_lh = f_hit(w_entry0, id_rs1, id_rs2, id_rs1_used, id_rs2_used) || w_sb_hit;

    // Multi-cycle FSM state and down-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_mc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mc    <= w_mc_nxt;
        end
    end

    // Multi-cycle FSM next state; a start while BUSY is ignored.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_state_nxt = r_state;
        w_mc_nxt    = r_mc;
        case (r_state)
            IDLE: begin
                if (ex_multi_start) begin
                    w_state_nxt = BUSY;
                    w_mc_nxt    = MC_W'(MULTI_LAT - 1);
                end
            end
            BUSY: begin
                w_mc_nxt = r_mc - MC_W'(1);
                if (r_mc == MC_W'(1)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_mc_nxt    = '0;
            end
        endcase
    end

    // Prioritised pipeline controls: reset, EX hold, branch squash, load hazard.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_hold      = 1'b0;
        stall        = 1'b0;
        if (rst) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (w_hold) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ex_hold     = 1'b1;
            stall       = 1'b1;
        end else if (branch_taken) begin
            // The ID instruction is squashed, so a pending load hazard is moot.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (w_lh) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            stall        = 1'b1;
        end
    end

    // Saturating stall-cycle performance counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: self-checking bench for hazard_ctrl.
// dut_a: LOAD_LAT=3, MULTI_LAT=4, CNT_W=4. dut_b: LOAD_LAT=1, MULTI_LAT=4, CNT_W=16.
// Both share the same stimulus. A table of single-cycle vectors, hand-written
// multi-cycle sequences, and a randomized run against a register-readiness
// reference model cover the design.
module tb_hazard_ctrl;

    localparam int MULTI_LAT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_rs1_used, id_rs2_used, ex_mem_read, ex_multi_start, branch_taken;

    logic        a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_bubble, a_ex_hold, a_stall;
    logic [3:0]  a_stall_cnt;
    logic        b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_bubble, b_ex_hold, b_stall;
    logic [15:0] b_stall_cnt;

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .MULTI_LAT(MULTI_LAT), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_multi_start(ex_multi_start),
        .branch_taken(branch_taken),
        .pc_write(a_pc_write), .if_id_write(a_if_id_write), .if_id_flush(a_if_id_flush),
        .id_ex_bubble(a_id_ex_bubble), .ex_hold(a_ex_hold), .stall(a_stall),
        .stall_cnt(a_stall_cnt)
    );

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .MULTI_LAT(MULTI_LAT), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_multi_start(ex_multi_start),
        .branch_taken(branch_taken),
        .pc_write(b_pc_write), .if_id_write(b_if_id_write), .if_id_flush(b_if_id_flush),
        .id_ex_bubble(b_id_ex_bubble), .ex_hold(b_ex_hold), .stall(b_stall),
        .stall_cnt(b_stall_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       mr;
        logic [4:0] rd;
        logic       br;
        logic       pc;
        logic       bub;
        logic       fl;
        logic       st;
    } vec_t;

    vec_t tbl [8];

    // Reference model state: per DUT, cycles each register stays not-ready
    // after a load left EX; remaining EX occupancy of a multi-cycle op.
    int ready [2][32];
    int lat   [2];
    int cmax  [2];
    int cnt   [2];
    int op_left;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic mr,
                          input logic [4:0] rd, input logic start, input logic br);
        id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
        ex_mem_read = mr; ex_rd = rd; ex_multi_start = start; branch_taken = br;
    endtask

    task automatic do_reset();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Model: is register r (if read) still waiting on a load for DUT d?
    function automatic logic reg_busy(input int d, input logic [4:0] r, input logic used);
        return used && (r != 5'd0) &&
               ((ex_mem_read && (ex_rd == r)) || (ready[d][r] > 0));
    endfunction

    // Watchdog so the run can never hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int         sa, sb;
        logic [7:0] hold_bits;

        // ---------------- reset state ----------------
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("rst_pc_write",   32'(a_pc_write), 1);
        check("rst_if_id_write", 32'(a_if_id_write), 1);
        check("rst_flush",      32'(a_if_id_flush), 1);
        check("rst_bubble",     32'(a_id_ex_bubble), 1);
        check("rst_ex_hold",    32'(a_ex_hold), 0);
        check("rst_stall",      32'(a_stall), 0);
        check("rst_cnt_a",      32'(a_stall_cnt), 0);
        tick();
        rst = 1'b0;

        // ---------------- table: single-cycle vectors on dut_b (LOAD_LAT=1) ----------------
        //            rs1    rs2    u1    u2    mr    rd     br    pc    bub   fl    st
        tbl[0] = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{5'd5, 5'd6, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            set_in(tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].mr,
                   tbl[i].rd, 1'b0, tbl[i].br);
            @(negedge clk);
            check($sformatf("tbl%0d_pc_write", i), 32'(b_pc_write),     32'(tbl[i].pc));
            check($sformatf("tbl%0d_bubble", i),   32'(b_id_ex_bubble), 32'(tbl[i].bub));
            check($sformatf("tbl%0d_flush", i),    32'(b_if_id_flush),  32'(tbl[i].fl));
            check($sformatf("tbl%0d_stall", i),    32'(b_stall),        32'(tbl[i].st));
            tick();
        end

        // ---------------- load-use, consumer directly behind the load ----------------
        do_reset();
        set_in(5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
        sa = 0; sb = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sa += int'(a_stall);
            sb += int'(b_stall);
            if (i == 0) begin
                check("lat1_first_pc_write", 32'(b_pc_write), 0);
                check("lat1_first_bubble",   32'(b_id_ex_bubble), 1);
            end
            if (i == 1) check("lat1_second_stall", 32'(b_stall), 0);
            tick();
            ex_mem_read = 1'b0;
            ex_rd       = 5'd0;
        end
        check("lat3_dist0_stalls", 32'(sa), 3);
        check("lat1_dist0_stalls", 32'(sb), 1);

        // ---------------- load-use with one independent instruction between ----------------
        set_in(5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
        sa = 0; sb = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sa += int'(a_stall);
            sb += int'(b_stall);
            tick();
            if (i == 0) begin
                id_rs1      = 5'd7;
                ex_mem_read = 1'b0;
                ex_rd       = 5'd3;
            end
        end
        check("lat3_dist1_stalls", 32'(sa), 2);
        check("lat1_dist1_stalls", 32'(sb), 0);

        // ---------------- no hazard: rd=0, or the operand is not read ----------------
        set_in(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("rd0_no_stall", 32'(a_stall), 0);
        tick();
        set_in(5'd7, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
        sa = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sa += int'(a_stall);
            tick();
            ex_mem_read = 1'b0;
        end
        check("unused_rs_stalls", 32'(sa), 0);

        // ---------------- multi-cycle op, restart and branch while busy ----------------
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        hold_bits = '0;
        for (int i = 0; i < 8; i++) begin
            ex_multi_start = (i < 2);
            branch_taken   = (i == 2);
            @(negedge clk);
            hold_bits[i] = a_ex_hold;
            if (a_ex_hold) check($sformatf("multi_pc_write_c%0d", i), 32'(a_pc_write), 0);
            if (i == 2) begin
                check("multi_branch_no_flush", 32'(a_if_id_flush), 0);
                check("multi_branch_stall",    32'(a_stall), 1);
            end
            tick();
        end
        branch_taken = 1'b0;
        check("multi_hold_pattern", 32'(hold_bits), 32'h07);

        // ---------------- load hazard together with a taken branch ----------------
        do_reset();
        set_in(5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1);
        @(negedge clk);
        check("lh_br_flush",    32'(a_if_id_flush), 1);
        check("lh_br_bubble",   32'(a_id_ex_bubble), 1);
        check("lh_br_pc_write", 32'(a_pc_write), 1);
        check("lh_br_stall",    32'(a_stall), 0);
        tick();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("lh_br_cnt_a", 32'(a_stall_cnt), 0);
        check("lh_br_cnt_b", 32'(b_stall_cnt), 0);
        for (int i = 0; i < 3; i++) tick();

        // ---------------- counter saturation (CNT_W=4 on dut_a) ----------------
        set_in(5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            if (i == 15) check("sat_cnt_a_at15", 32'(a_stall_cnt), 15);
            if (i == 20) begin
                check("sat_cnt_a_at20", 32'(a_stall_cnt), 15);
                check("sat_cnt_b_at20", 32'(b_stall_cnt), 20);
            end
            tick();
        end

        // ---------------- reset during BUSY with a load in the scoreboard ----------------
        do_reset();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd11, 1'b0, 1'b0);
        tick();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        ex_multi_start = 1'b0;
        @(negedge clk);
        check("rbusy_hold_before", 32'(a_ex_hold), 1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("rbusy_hold_in_rst",  32'(a_ex_hold), 0);
        check("rbusy_flush_in_rst", 32'(a_if_id_flush), 1);
        tick();
        rst = 1'b0;
        id_rs1      = 5'd11;
        id_rs1_used = 1'b1;
        @(negedge clk);
        check("rbusy_hold_after",  32'(a_ex_hold), 0);
        check("rbusy_no_stale_lh", 32'(a_stall), 0);
        check("rbusy_cnt_a",       32'(a_stall_cnt), 0);
        check("rbusy_cnt_b",       32'(b_stall_cnt), 0);
        tick();
        @(negedge clk);
        check("rbusy_stays_idle", 32'(a_ex_hold), 0);
        tick();

        // ---------------- randomized run against the reference model ----------------
        do_reset();
        lat[0] = 3;  lat[1] = 1;
        cmax[0] = 15; cmax[1] = 65535;
        cnt[0] = 0;  cnt[1] = 0;
        op_left = 0;
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 32; r++) ready[d][r] = 0;

        for (int c = 0; c < 600; c++) begin
            logic        hold_m;
            logic        lh, pc, ifid, fl, bub, st;
            logic [31:0] expv, actv;

            rst            = ($urandom_range(0, 49) == 0);
            id_rs1         = 5'($urandom_range(0, 3));
            id_rs2         = 5'($urandom_range(0, 3));
            id_rs1_used    = 1'($urandom_range(0, 1));
            id_rs2_used    = 1'($urandom_range(0, 1));
            ex_mem_read    = 1'($urandom_range(0, 1));
            ex_rd          = 5'($urandom_range(0, 3));
            ex_multi_start = ($urandom_range(0, 15) == 0);
            branch_taken   = ($urandom_range(0, 9) == 0);

            hold_m = !rst && (((op_left == 0) && ex_multi_start) || (op_left > 1));

            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                lh = reg_busy(d, id_rs1, id_rs1_used) || reg_busy(d, id_rs2, id_rs2_used);
                if (rst)               {pc, ifid, fl, bub, st} = 5'b11110;
                else if (hold_m)       {pc, ifid, fl, bub, st} = 5'b00001;
                else if (branch_taken) {pc, ifid, fl, bub, st} = 5'b11110;
                else if (lh)           {pc, ifid, fl, bub, st} = 5'b00011;
                else                   {pc, ifid, fl, bub, st} = 5'b11000;
                expv = {10'b0, pc, ifid, fl, bub, (hold_m && !rst), st, 16'(cnt[d])};
                if (d == 0)
                    actv = {10'b0, a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_bubble,
                            a_ex_hold, a_stall, 12'b0, a_stall_cnt};
                else
                    actv = {10'b0, b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_bubble,
                            b_ex_hold, b_stall, b_stall_cnt};
                check($sformatf("rand_c%0d_dut%0d", c, d), actv, expv);

                // advance this DUT's model to the next cycle
                if (rst) begin
                    cnt[d] = 0;
                    for (int r = 0; r < 32; r++) ready[d][r] = 0;
                end else begin
                    if (st && (cnt[d] < cmax[d])) cnt[d]++;
                    if (!hold_m) begin
                        for (int r = 0; r < 32; r++)
                            if (ready[d][r] > 0) ready[d][r]--;
                        if (ex_mem_read && (ex_rd != 5'd0))
                            ready[d][ex_rd] = lat[d] - 1;
                    end
                end
            end
            if (rst)                                    op_left = 0;
            else if ((op_left == 0) && ex_multi_start)  op_left = MULTI_LAT - 1;
            else if (op_left > 0)                       op_left--;
            tick();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised pipeline hazard controller for the 5-stage RV32 core. It supersedes the single-cycle, combinational load-use detector.
- Tracks in-flight loads with a configurable load-to-use latency. Freezes the front end for a multi-cycle EX unit (MUL/DIV) and generates branch flushes.
- Keeps a saturating stall-cycle performance counter.
- Sits beside the IF/ID and ID/EX pipeline registers and drives their enables and bubbles.

Parameters:
- REG_AW, 5, register address width.
- LOAD_LAT, 1, stall cycles a dependent instruction needs after a load enters EX (1..4). LOAD_LAT=1 equals classic load-use.
- MULTI_LAT, 4, cycles a multi-cycle EX op occupies EX (2..32).
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- id_rs1  in  REG_AW  rs1 of the instruction in ID
- id_rs2  in  REG_AW  rs2 of the instruction in ID
- id_rs1_used  in  1  instruction in ID reads rs1
- id_rs2_used  in  1  instruction in ID reads rs2
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  REG_AW  destination of the instruction in EX
- ex_multi_start  in  1  instruction in EX is a multi-cycle op (first EX cycle)
- branch_taken  in  1  EX resolved a taken branch/jump
- pc_write  out  1  PC enable
- if_id_write  out  1  IF/ID enable
- if_id_flush  out  1  IF/ID clear to NOP
- id_ex_bubble  out  1  load NOP into ID/EX
- ex_hold  out  1  hold ID/EX and EX/MEM, keep EX op running
- stall  out  1  any front-end stall this cycle
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Load scoreboard: shift register sb[1..LOAD_LAT-1] of {valid, rd}. Entry 0 is combinational: {ex_mem_read && ex_rd!=0, ex_rd}.
  - Each cycle without ex_hold: sb[1] <= entry0 and sb[k+1] <= sb[k].
  - When ex_hold=1 the scoreboard does not shift.
  - For LOAD_LAT=1 the shift register is empty.
- Load hazard (lh): any valid entry k in 0..LOAD_LAT-1 whose rd matches (id_rs1 && id_rs1_used) or (id_rs2 && id_rs2_used).
  - rd=0 never matches.
- Multi-cycle FSM: IDLE, BUSY with down-counter mc of width clog2(MULTI_LAT).
  - IDLE & ex_multi_start: go to BUSY, mc <= MULTI_LAT-1. ex_hold=1 starting in that same cycle.
  - BUSY: ex_hold=1. Decrement each cycle. When mc==1, go to IDLE next cycle.
  - Total ex_hold cycles = MULTI_LAT-1; the op leaves EX on the MULTI_LAT-th cycle.
  - ex_multi_start is ignored while BUSY.
- Output priority, evaluated per cycle:
  1. rst: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1, ex_hold=0, stall=0.
  2. ex_hold (IDLE&start or BUSY): pc_write=0, if_id_write=0, id_ex_bubble=0, if_id_flush=0, stall=1. branch_taken is ignored.
  3. branch_taken (only in IDLE without start): pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1, stall=0. This overrides lh, because the ID instruction is squashed.
  4. lh: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0, stall=1.
  5. Otherwise: pc_write=1, if_id_write=1, flush=0, bubble=0, stall=0.
- All outputs are combinational from current state and inputs; there is no added latency.
- Because bubbles advance the scoreboard, a dependent instruction stalls exactly (LOAD_LAT - distance) cycles. Distance = number of instructions between the load and the consumer.
- stall_cnt: increments when stall=1. Saturates at all-ones and never wraps.
- Reset:
  - Takes effect on the next clk edge.
  - Clears sb, returns FSM to IDLE with mc=0, sets stall_cnt=0.
  - Reset mid-BUSY aborts immediately; the first post-reset cycle is IDLE.

Test Plan:
- LOAD_LAT=1: lw x5 in EX, ID reads x5 as rs2 (used) -> one cycle stall=1, pc_write=0, id_ex_bubble=1; next cycle stall=0.
- LOAD_LAT=3: lw x7, then a dependent instruction directly behind it -> 3 consecutive stall cycles. Same dependency with one independent instruction between -> 2 cycles. ex_rd=0 or rs_used=0 -> 0 stalls.
- MULTI_LAT=4: ex_multi_start pulse -> ex_hold=1 for exactly 3 cycles, pc_write=0 throughout. A second start during BUSY is ignored. branch_taken during BUSY -> no flush.
- Load hazard and branch_taken in the same cycle -> if_id_flush=1, id_ex_bubble=1, pc_write=1, stall=0, stall_cnt unchanged.
- CNT_W=4: force 20 stall cycles -> stall_cnt saturates at 15.
- rst asserted in the second BUSY cycle with a valid sb entry -> next cycle FSM IDLE, ex_hold=0, no stale load hazard, stall_cnt=0.
